// File: rtl/mix_pkg.sv
// mix_pkg: state encoding, control characters and MIX-to-ASCII table for tty_out (rev 1.0)
`default_nettype none

package mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } tty_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
        logic [7:0] c;
        logic [7:0] r;
        c = {2'b00, code};
        if (code == 6'd0)        r = 8'h20;
        else if (code <= 6'd9)   r = c + 8'h40;
        else if (code == 6'd10)  r = 8'h7E;
        else if (code <= 6'd19)  r = c + 8'h3F;
        else if (code == 6'd20)  r = 8'h5B;
        else if (code == 6'd21)  r = 8'h5D;
        else if (code <= 6'd29)  r = c + 8'h3D;
        else if (code <= 6'd39)  r = c + 8'h12;
        else begin
            case (code)
                6'd40:   r = 8'h2E;
                6'd41:   r = 8'h2C;
                6'd42:   r = 8'h28;
                6'd43:   r = 8'h29;
                6'd44:   r = 8'h2B;
                6'd45:   r = 8'h2D;
                6'd46:   r = 8'h2A;
                6'd47:   r = 8'h2F;
                6'd48:   r = 8'h3D;
                6'd49:   r = 8'h24;
                6'd50:   r = 8'h3C;
                6'd51:   r = 8'h3E;
                6'd52:   r = 8'h40;
                6'd53:   r = 8'h3B;
                6'd54:   r = 8'h3A;
                6'd55:   r = 8'h27;
                default: r = 8'h3F;
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tty_out_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready is also high in the last stop-bit cycle so frames can abut (rev 1.0)
`default_nettype none

module uart_tx_byte #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic             active_q, active_d;
    logic             tx_q, tx_d;
    logic [8:0]       frame_q, frame_d;
    logic [3:0]       bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign ready   = !active_q || (bit_end && (bits_q == 4'd0));
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            frame_q  <= '0;
            bits_q   <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            frame_q  <= frame_d;
            bits_q   <= bits_d;
            cnt_q    <= cnt_d;
        end
    end

    // frame_q holds the bits still to go out: data LSB first, then the stop bit
    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        frame_d  = frame_q;
        bits_d   = bits_q;
        cnt_d    = cnt_q;
        if (ready && send) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            frame_d  = {1'b1, data};
            bits_d   = 4'd9;
            cnt_d    = '0;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bits_q == 4'd0) begin
                    active_d = 1'b0;
                end else begin
                    tx_d    = frame_q[0];
                    frame_d = {1'b1, frame_q[8:1]};
                    bits_d  = bits_q - 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tty_out.sv
// tty_out: MIX unit 19 block output; steals memory reads, prints 5 chars per word, ends with CR LF (rev 1.0)
`default_nettype none

module tty_out
    import mix_pkg::*;
#(
    parameter int BAUD_DIV = 104,
    parameter int WORDS    = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] addressin,
    output logic        stop,
    output logic        busy,
    output logic        request,
    output logic [11:0] addressout,
    input  logic        load,
    input  logic [29:0] in,
    output logic        tx
);

    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS + 1) : 1;
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

    tty_state_t        state_q, state_d;
    logic [11:0]       addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [29:0]       shift_q, shift_d;
    logic [2:0]        chars_q, chars_d;
    logic              stop_q;

    logic              uart_send;
    logic              uart_ready;
    logic [7:0]        uart_data;

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk  (clk),
        .reset(reset),
        .data (uart_data),
        .send (uart_send),
        .ready(uart_ready),
        .tx   (tx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            shift_q <= '0;
            chars_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            chars_q <= chars_d;
            stop_q  <= start;
        end
    end

    // The first character leaves in the load cycle, so shift_q keeps only
    // the four that remain and chars_q counts them down.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        shift_d = shift_q;
        chars_d = chars_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = addressin;
                    word_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (load) begin
                    shift_d = {in[23:0], 6'b0};
                    chars_d = 3'd4;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (uart_ready) begin
                    if (chars_q != 3'd0) begin
                        shift_d = {shift_q[23:0], 6'b0};
                        chars_d = chars_q - 3'd1;
                    end else begin
                        word_d  = word_q + 1'b1;
                        addr_d  = addr_q + 12'd1;
                        state_d = (word_q == WORD_LAST) ? ST_CR : ST_FETCH;
                    end
                end
            end
            ST_CR: begin
                if (uart_ready) state_d = ST_LF;
            end
            ST_LF: begin
                if (uart_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CR is launched from SEND and LF from CR so that every frame abuts the last
    always_comb begin
        request   = (state_q == ST_FETCH);
        busy      = (state_q != ST_IDLE);
        uart_send = 1'b0;
        uart_data = mix_to_ascii(shift_q[29:24]);
        case (state_q)
            ST_FETCH: begin
                uart_send = load;
                uart_data = mix_to_ascii(in[29:24]);
            end
            ST_SEND: begin
                if (uart_ready) begin
                    if (chars_q != 3'd0) begin
                        uart_send = 1'b1;
                    end else if (word_q == WORD_LAST) begin
                        uart_send = 1'b1;
                        uart_data = ASCII_CR;
                    end
                end
            end
            ST_CR: begin
                uart_send = uart_ready;
                uart_data = ASCII_LF;
            end
            default: ;
        endcase
    end

    assign stop       = stop_q;
    assign addressout = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_tty_out.sv
// tb_tty_out: directed bench for tty_out with one-word and two-word blocks (rev 1.0)
`default_nettype none

module tb_tty_out;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, stop1, busy1, request1, load1, tx1;
    logic [11:0] addrin1, addrout1;
    logic [29:0] in1;
    logic        start2, stop2, busy2, request2, load2, tx2;
    logic [11:0] addrin2, addrout2;
    logic [29:0] in2;

    always #5 clk = ~clk;

    tty_out #(.BAUD_DIV(B), .WORDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .addressin(addrin1),
        .stop(stop1), .busy(busy1), .request(request1), .addressout(addrout1),
        .load(load1), .in(in1), .tx(tx1)
    );

    tty_out #(.BAUD_DIV(B), .WORDS(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .addressin(addrin2),
        .stop(stop2), .busy(busy2), .request(request2), .addressout(addrout2),
        .load(load2), .in(in2), .tx(tx2)
    );

    logic [29:0] mem [0:4095];
    int          cyc = 0;
    int          vectors = 0;
    int          errs = 0;
    bit          auto1 = 1'b1;
    int          rc1 = 0;
    int          rc2 = 0;
    int          q1[$];
    int          q2[$];
    logic [7:0]  expq[$];
    logic        sel = 1'b0;
    logic        rx_line;

    assign rx_line = sel ? tx2 : tx1;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers one cycle after request is first seen
    always @(negedge clk) begin
        if (auto1) begin
            if (request1 === 1'b1) begin
                if (rc1 == 1) begin
                    load1 = 1'b1; in1 = mem[addrout1]; q1.push_back(int'(addrout1)); rc1 = 0;
                end else begin
                    load1 = 1'b0; rc1++;
                end
            end else begin
                load1 = 1'b0; rc1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (request2 === 1'b1) begin
            if (rc2 == 1) begin
                load2 = 1'b1; in2 = mem[addrout2]; q2.push_back(int'(addrout2)); rc2 = 0;
            end else begin
                load2 = 1'b0; rc2++;
            end
        end else begin
            load2 = 1'b0; rc2 = 0;
        end
    end

    function automatic logic [29:0] w5(input int a, input int b, input int c, input int d, input int e);
        return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the middle of the stop bit
    task automatic rx_byte(input string tag, input logic [7:0] exp, output int s_cyc);
        logic [7:0] b;
        int n;
        n = 0;
        while (rx_line !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        s_cyc = cyc;
        if (rx_line !== 1'b0) begin
            check({tag, "_startbit"}, 32'(rx_line), 32'd0);
        end else begin
            repeat (B + B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = rx_line;
                repeat (B) @(negedge clk);
            end
            check(tag, 32'(b), 32'(exp));
            check({tag, "_stopbit"}, 32'(rx_line), 32'd1);
        end
    endtask

    task automatic rx_seq(input string tag, output int first_s);
        int s;
        first_s = -1;
        for (int i = 0; expq.size() > 0; i++) begin
            rx_byte($sformatf("%s_ch%0d", tag, i), expq.pop_front(), s);
            if (i == 0) first_s = s;
        end
    endtask

    initial begin
        int s, k0, n;
        reset = 1'b1;
        start1 = 1'b0; addrin1 = '0; load1 = 1'b0; in1 = '0;
        start2 = 1'b0; addrin2 = '0; load2 = 1'b0; in2 = '0;
        mem[100]  = w5(8, 5, 13, 13, 16);
        mem[200]  = w5(10, 20, 21, 55, 63);
        mem[300]  = w5(1, 2, 3, 4, 5);
        mem[4095] = w5(30, 31, 32, 33, 34);
        mem[0]    = w5(40, 41, 42, 43, 44);
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx1), 32'd1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_request", 32'(request1), 32'd0);
        check("rst_stop", 32'(stop1), 32'd0);
        check("rst_addressout", 32'(addrout1), 32'd0);
        check("rst_tx2", 32'(tx2), 32'd1);
        reset = 1'b0;

        // HELLO, exact start-bit and busy timing
        @(negedge clk); k0 = cyc; start1 = 1'b1; addrin1 = 12'd100;
        @(negedge clk); start1 = 1'b0;
        check("hello_stop", 32'(stop1), 32'd1);
        check("hello_addr", 32'(addrout1), 32'd100);
        check("hello_busy", 32'(busy1), 32'd1);
        check("hello_request", 32'(request1), 32'd1);
        @(negedge clk);
        check("hello_stop_low", 32'(stop1), 32'd0);
        expq = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
        rx_seq("hello", s);
        check("hello_first_start", 32'(s - k0), 32'd3);
        n = 0;
        while (busy1 === 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("hello_busy_fall", 32'(cyc - k0), 32'd283);

        // Special codes, with a second start while busy
        q1.delete();
        @(negedge clk); start1 = 1'b1; addrin1 = 12'd200;
        @(negedge clk); start1 = 1'b0;
        check("sym_stop", 32'(stop1), 32'd1);
        rx_byte("sym_ch0", 8'h7E, s);
        @(negedge clk); start1 = 1'b1; addrin1 = 12'd500;
        @(negedge clk); start1 = 1'b0;
        check("busy_start_stop", 32'(stop1), 32'd1);
        check("busy_start_addr", 32'(addrout1), 32'd200);
        expq = '{8'h5B, 8'h5D, 8'h27, 8'h3F, 8'h0D, 8'h0A};
        rx_seq("sym", s);
        n = 0;
        while (busy1 === 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("sym_idle", 32'(busy1), 32'd0);
        check("sym_req_count", 32'(q1.size()), 32'd1);
        if (q1.size() > 0) check("sym_req_addr", 32'(q1[0]), 32'd200);
        check("sym_addr_after", 32'(addrout1), 32'd201);

        // Load held off for 7 cycles
        auto1 = 1'b0;
        @(negedge clk); start1 = 1'b1; addrin1 = 12'd300;
        @(negedge clk); start1 = 1'b0;
        check("dly_stop", 32'(stop1), 32'd1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("dly_request_%0d", i), 32'(request1), 32'd1);
            check($sformatf("dly_addr_%0d", i), 32'(addrout1), 32'd300);
            check($sformatf("dly_tx_%0d", i), 32'(tx1), 32'd1);
            @(negedge clk);
        end
        load1 = 1'b1; in1 = mem[300];
        @(negedge clk); load1 = 1'b0;
        check("dly_startbit", 32'(tx1), 32'd0);
        check("dly_request_low", 32'(request1), 32'd0);
        auto1 = 1'b1;
        expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0D, 8'h0A};
        rx_seq("dly", s);
        n = 0;
        while (busy1 === 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("dly_idle", 32'(busy1), 32'd0);

        // Reset in the third bit of a character, then a clean block
        @(negedge clk); start1 = 1'b1; addrin1 = 12'd100;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (tx1 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        repeat (2 * B + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_tx", 32'(tx1), 32'd1);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_request", 32'(request1), 32'd0);
        @(negedge clk); start1 = 1'b1; addrin1 = 12'd300;
        @(negedge clk); start1 = 1'b0;
        expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0D, 8'h0A};
        rx_seq("after_abort", s);

        // Two-word block wrapping from 4095 to 0
        sel = 1'b1;
        @(negedge clk); start2 = 1'b1; addrin2 = 12'd4095;
        @(negedge clk); start2 = 1'b0;
        check("wrap_stop", 32'(stop2), 32'd1);
        check("wrap_addr", 32'(addrout2), 32'd4095);
        expq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                 8'h2E, 8'h2C, 8'h28, 8'h29, 8'h2B, 8'h0D, 8'h0A};
        rx_seq("wrap", s);
        n = 0;
        while (busy2 === 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("wrap_idle", 32'(busy2), 32'd0);
        check("wrap_req_count", 32'(q2.size()), 32'd2);
        if (q2.size() > 1) begin
            check("wrap_req0", 32'(q2[0]), 32'd4095);
            check("wrap_req1", 32'(q2[1]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
